// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// requester ids and the default RAM depth.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Requester ids double as bit positions in the request/grant vectors.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int MEM_DEPTH = 512;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins,
// a lone request is granted regardless of history.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[REQ_FETCH] && req[REQ_DATA]) begin
      if (last == REQ_FETCH) grant[REQ_DATA] = 1'b1;
      else                   grant[REQ_FETCH] = 1'b1;
    end else if (req[REQ_DATA]) begin
      grant[REQ_DATA] = 1'b1;
    end else if (req[REQ_FETCH]) begin
      grant[REQ_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between a fetch and a data requester using a
// three-cycle IDLE -> ACCESS -> RESP transaction with round-robin arbitration.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic              grant_id;
  logic              lat_we;
  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              start;
  logic              in_range;
  logic              load_rdata;
  logic [DATA_W-1:0] rdata_next;

  assign req_vec  = {d_req, f_req};
  assign start    = (state == ST_IDLE) && (f_req || d_req);
  // ram_addr already holds the granted address for the whole transaction.
  assign in_range = {1'b0, ram_addr} < DEPTH_LIM;
  assign busy     = (state != ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req   (req_vec),
    .last  (grant_id),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    f_ack      = 1'b0;
    d_ack      = 1'b0;
    f_err      = 1'b0;
    d_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (f_req || d_req) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_read   = in_range && !lat_we;
        ram_write  = in_range && lat_we;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (grant_id == REQ_FETCH) begin
          f_ack = 1'b1;
          f_err = !in_range;
        end else begin
          d_ack = 1'b1;
          d_err = !in_range;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant id doubles as the round-robin history; it updates on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= REQ_FETCH;
      lat_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else if (start) begin
      grant_id <= grant[REQ_DATA];
      if (grant[REQ_FETCH]) begin
        lat_we   <= 1'b0;
        ram_addr <= f_addr;
        ram_din  <= '0;
      end else begin
        lat_we   <= d_we;
        ram_addr <= d_addr;
        ram_din  <= d_wdata;
      end
    end
  end

  // Reads capture RAM data; an out-of-range access of either kind returns 0.
  assign load_rdata = (state == ST_ACCESS) && (!lat_we || !in_range);
  assign rdata_next = in_range ? ram_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rdata <= '0;
      d_rdata <= '0;
    end else if (load_rdata) begin
      if (grant_id == REQ_FETCH) f_rdata <= rdata_next;
      else                       d_rdata <= rdata_next;
    end
  end

endmodule
